// File: rtl/alu_issue_stage.sv
// Operand/issue sequencer for the 16-bit ALU: one instruction in flight,
// IDLE -> EXEC -> WB, with an 8 x 16 register file (r0 reads as zero).
module alu_issue_stage #(
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_rt,
    input  logic          instr_imm_en,
    input  logic [15:0]   instr_imm,
    input  logic          instr_half,
    input  logic          instr_byte,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output logic          alu_subtract,
    output logic          alu_mult,
    output logic          alu_and,
    output logic          alu_or,
    output logic          alu_xor,
    output logic          alu_not,
    output logic          alu_l_shift,
    output logic          alu_r_shift,
    output logic          alu_half_mode,
    output logic          alu_bytewise_mode,
    input  logic [15:0]   alu_sum,
    input  logic          alu_cout,
    input  logic          alu_z,
    output logic          flag_c,
    output logic          flag_z,
    output logic          done,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    // state | meaning
    // IDLE  | ready for a new instruction
    // EXEC  | operands on ALU inputs, ALU settling
    // WB    | result captured, write-back on next edge
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   regs [NREGS];
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [15:0]   sum_q;
    logic          cout_q, z_q;
    logic [7:0]    sel_q, sel_d;
    logic [15:0]   a_d, b_d, rs_data, rt_data;
    logic          half_d, byte_d;
    logic          wr_en, flag_en;

    assign rs_data  = (instr_rs == '0) ? 16'h0000 : regs[instr_rs];
    assign rt_data  = (instr_rt == '0) ? 16'h0000 : regs[instr_rt];
    assign dbg_data = (dbg_addr == '0) ? 16'h0000 : regs[dbg_addr];

    assign {alu_subtract, alu_mult, alu_and, alu_or,
            alu_xor, alu_not, alu_l_shift, alu_r_shift} = sel_q;

    always_comb begin
        sel_d  = 8'h00;
        a_d    = rs_data;
        b_d    = instr_imm_en ? instr_imm : rt_data;
        half_d = instr_half;
        byte_d = instr_byte;
        case (instr_op)
            4'd0:       sel_d = 8'b0000_0000;
            4'd1, 4'd9: sel_d = 8'b1000_0000;
            4'd2:       sel_d = 8'b0100_0000;
            4'd3:       sel_d = 8'b0010_0000;
            4'd4:       sel_d = 8'b0001_0000;
            4'd5:       sel_d = 8'b0000_1000;
            4'd6:       sel_d = 8'b0000_0100;
            4'd7:       sel_d = 8'b0000_0010;
            4'd8:       sel_d = 8'b0000_0001;
            4'd10: begin
                b_d    = 16'h0000;
                half_d = 1'b0;
                byte_d = 1'b0;
            end
            4'd11: begin
                a_d    = 16'h0000;
                b_d    = instr_imm;
                half_d = 1'b0;
                byte_d = 1'b0;
            end
            default: begin
                half_d = 1'b0;
                byte_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = EXEC;
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // CMP and NOP never write; MOV/LDI/NOP leave flags alone
    assign wr_en   = ((op_q <= 4'd8) || (op_q == 4'd10) || (op_q == 4'd11)) && (rd_q != '0);
    assign flag_en = (op_q <= 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
            op_q              <= 4'h0;
            rd_q              <= '0;
            sum_q             <= 16'h0000;
            cout_q            <= 1'b0;
            z_q               <= 1'b0;
            alu_a             <= 16'h0000;
            alu_b             <= 16'h0000;
            sel_q             <= 8'h00;
            alu_half_mode     <= 1'b0;
            alu_bytewise_mode <= 1'b0;
            flag_c            <= 1'b0;
            flag_z            <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        op_q              <= instr_op;
                        rd_q              <= instr_rd;
                        alu_a             <= a_d;
                        alu_b             <= b_d;
                        sel_q             <= sel_d;
                        alu_half_mode     <= half_d;
                        alu_bytewise_mode <= byte_d;
                    end
                end
                EXEC: begin
                    sum_q  <= alu_sum;
                    cout_q <= alu_cout;
                    z_q    <= alu_z;
                end
                WB: begin
                    if (wr_en) regs[rd_q] <= sum_q;
                    if (flag_en) begin
                        flag_c <= cout_q;
                        flag_z <= z_q;
                    end
                    alu_a             <= 16'h0000;
                    alu_b             <= 16'h0000;
                    sel_q             <= 8'h00;
                    alu_half_mode     <= 1'b0;
                    alu_bytewise_mode <= 1'b0;
                    done              <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the DUT's ALU port, reference
// register/flag model, directed plan steps plus random instructions.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = 4'h0;
    logic [2:0]  instr_rd = 3'd0, instr_rs = 3'd0, instr_rt = 3'd0;
    logic        instr_imm_en = 1'b0;
    logic [15:0] instr_imm = 16'h0;
    logic        instr_half = 1'b0, instr_byte = 1'b0;
    logic [15:0] alu_a, alu_b;
    logic        alu_subtract, alu_mult, alu_and, alu_or, alu_xor, alu_not, alu_l_shift, alu_r_shift;
    logic        alu_half_mode, alu_bytewise_mode;
    logic [15:0] alu_sum;
    logic        alu_cout, alu_z;
    logic        flag_c, flag_z, done;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mregs [8];
    logic        mc = 1'b0, mz = 1'b0;

    always #10 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .instr_half(instr_half), .instr_byte(instr_byte),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_subtract(alu_subtract), .alu_mult(alu_mult), .alu_and(alu_and), .alu_or(alu_or),
        .alu_xor(alu_xor), .alu_not(alu_not), .alu_l_shift(alu_l_shift), .alu_r_shift(alu_r_shift),
        .alu_half_mode(alu_half_mode), .alu_bytewise_mode(alu_bytewise_mode),
        .alu_sum(alu_sum), .alu_cout(alu_cout), .alu_z(alu_z),
        .flag_c(flag_c), .flag_z(flag_z), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    logic [7:0] dut_sel;
    assign dut_sel = {alu_subtract, alu_mult, alu_and, alu_or, alu_xor, alu_not, alu_l_shift, alu_r_shift};

    // Returns {cout, z, sum}; half mode works on the low bytes, carry = any bit above 7
    function automatic logic [17:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] sel, input logic half);
        logic [31:0] am, bm, r;
        logic [15:0] s;
        logic        c;
        am = half ? {24'h0, a[7:0]} : {16'h0, a};
        bm = half ? {24'h0, b[7:0]} : {16'h0, b};
        if      (sel[7]) r = am - bm;
        else if (sel[6]) r = am * bm;
        else if (sel[5]) r = am & bm;
        else if (sel[4]) r = am | bm;
        else if (sel[3]) r = am ^ bm;
        else if (sel[2]) r = {16'h0, ~am[15:0]};
        else if (sel[1]) r = am << 1;
        else if (sel[0]) r = am >> 1;
        else             r = am + bm;
        if (half) begin
            s = {8'h00, r[7:0]};
            c = |r[16:8];
        end else begin
            s = r[15:0];
            c = |r[31:16];
        end
        return {c, (s == 16'h0000), s};
    endfunction

    always_comb {alu_cout, alu_z, alu_sum} = alu_fn(alu_a, alu_b, dut_sel, alu_half_mode);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("dbg_r%0d", i), {16'h0, dbg_data}, {16'h0, mregs[i]});
        end
    endtask

    // Starts and ends at a negedge with the DUT in IDLE
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [2:0] rt, input logic imm_en, input logic [15:0] imm,
                             input logic half, input logic bytem);
        logic [15:0] ea, eb;
        logic [7:0]  es;
        logic        eh, ey;
        logic [17:0] res;
        check("ready_idle", {31'h0, instr_ready}, 32'h1);
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        instr_imm_en = imm_en; instr_imm = imm; instr_half = half; instr_byte = bytem;
        instr_valid = 1'b1;
        ea = (op == 4'd11) ? 16'h0 : mregs[rs];
        if      (op == 4'd10) eb = 16'h0;
        else if (op == 4'd11) eb = imm;
        else                  eb = imm_en ? imm : mregs[rt];
        if      (op >= 4'd1 && op <= 4'd8) es = 8'h80 >> (op - 4'd1);
        else if (op == 4'd9)               es = 8'h80;
        else                               es = 8'h00;
        eh = (op <= 4'd9) ? half : 1'b0;
        ey = (op <= 4'd9) ? bytem : 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op = 4'($urandom); instr_rd = 3'($urandom); instr_rs = 3'($urandom);
        instr_rt = 3'($urandom); instr_imm = 16'($urandom); instr_imm_en = 1'($urandom);
        instr_half = 1'($urandom); instr_byte = 1'($urandom);
        @(negedge clk);
        check("ready_exec", {31'h0, instr_ready}, 32'h0);
        check("alu_a", {16'h0, alu_a}, {16'h0, ea});
        check("alu_b", {16'h0, alu_b}, {16'h0, eb});
        check("alu_sel", {24'h0, dut_sel}, {24'h0, es});
        check("alu_modes", {30'h0, alu_half_mode, alu_bytewise_mode}, {30'h0, eh, ey});
        res = alu_fn(ea, eb, es, eh);
        @(negedge clk);
        check("ready_wb", {31'h0, instr_ready}, 32'h0);
        check("alu_a_stable", {16'h0, alu_a}, {16'h0, ea});
        check("done_early", {31'h0, done}, 32'h0);
        if ((op <= 4'd8 || op == 4'd10 || op == 4'd11) && rd != 3'd0) mregs[rd] = res[15:0];
        if (op <= 4'd9) begin
            mc = res[17];
            mz = res[16];
        end
        @(negedge clk);
        check("done_pulse", {31'h0, done}, 32'h1);
        check("ready_after", {31'h0, instr_ready}, 32'h1);
        check("alu_cleared", {8'h0, alu_a, dut_sel}, 32'h0);
        check("flags", {30'h0, flag_c, flag_z}, {30'h0, mc, mz});
        check_regs();
        @(negedge clk);
        check("done_drop", {31'h0, done}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, instr_ready}, 32'h1);
        check("rst_alu", {8'h0, alu_a, dut_sel}, 32'h0);
        check("rst_outs", {28'h0, flag_c, flag_z, done, alu_half_mode}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs();

        run_instr(4'd11, 3'd1, 3'd0, 3'd0, 1'b0, 16'h1234, 1'b0, 1'b0);
        run_instr(4'd11, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0005, 1'b0, 1'b0);
        run_instr(4'd11, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b0, 1'b0);
        run_instr(4'd9,  3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_instr(4'd11, 3'd1, 3'd0, 3'd0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_instr(4'd11, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_instr(4'd0,  3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_instr(4'd10, 3'd3, 3'd2, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_instr(4'd0,  3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_instr(4'd11, 3'd0, 3'd0, 3'd0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        run_instr(4'd11, 3'd5, 3'd0, 3'd0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_instr(4'd11, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0003, 1'b0, 1'b0);
        run_instr(4'd2,  3'd4, 3'd5, 3'd6, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_instr(4'd13, 3'd4, 3'd5, 3'd6, 1'b1, 16'h7777, 1'b1, 1'b1);

        // valid held high: accepts only every third edge
        instr_op = 4'd11; instr_rd = 3'd7; instr_rs = 3'd0; instr_rt = 3'd0;
        instr_imm_en = 1'b0; instr_imm = 16'h00A5; instr_half = 1'b0; instr_byte = 1'b0;
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("hold_ready", {31'h0, instr_ready}, {31'h0, (i % 3 == 0)});
            check("hold_done", {31'h0, done}, {31'h0, (i % 3 == 0) && (i > 0)});
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("hold_done_last", {31'h0, done}, 32'h1);
        mregs[7] = 16'h00A5;
        check_regs();
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            run_instr(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                      1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // make r1 write and flag update observable, then reset mid-EXEC
        run_instr(4'd11, 3'd2, 3'd0, 3'd0, 1'b0, 16'h8000, 1'b0, 1'b0);
        run_instr(4'd0,  3'd3, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("pre_rst_flagc", {31'h0, flag_c}, 32'h1);
        instr_op = 4'd0; instr_rd = 3'd1; instr_rs = 3'd2; instr_rt = 3'd2; instr_imm_en = 1'b0;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, instr_ready}, 32'h1);
        check("abort_alu", {8'h0, alu_a, dut_sel}, 32'h0);
        check("abort_flags_done", {29'h0, flag_c, flag_z, done}, 32'h0);
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        mc = 1'b0;
        mz = 1'b0;
        check_regs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_done_hold", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs();
        run_instr(4'd11, 3'd1, 3'd0, 3'd0, 1'b0, 16'h4321, 1'b0, 1'b0);
        run_instr(4'd0,  3'd2, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand/issue stage that sits directly upstream of the 16-bit ALU and consumes its result. Accepts one decoded instruction per valid/ready handshake, reads operands from an 8-entry x 16-bit register file, drives the ALU's operand and one-hot control inputs from registers, then captures sum/cout/z and writes back the destination register and the C/Z flags. It is a 3-state sequencer with one instruction in flight at a time.

## Interface
- NREGS, 8, register file depth; r0 hardwired to zero; address width = log2(NREGS)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  stage can accept; high only in IDLE
- instr_op  in  4  opcode (see Operation)
- instr_rd / instr_rs / instr_rt  in  3 each  destination / source A / source B
- instr_imm_en  in  1  replace B operand with instr_imm
- instr_imm  in  16  immediate
- instr_half  in  1  request ALU half (8-bit) mode
- instr_byte  in  1  request ALU bytewise (logical-boolean) mode
- alu_a, alu_b  out  16  registered operands to ALU
- alu_subtract, alu_mult, alu_and, alu_or, alu_xor, alu_not, alu_l_shift, alu_r_shift  out  1 each  registered one-hot op select; all 0 = add
- alu_half_mode, alu_bytewise_mode  out  1 each  registered mode selects
- alu_sum  in  16  ALU result
- alu_cout, alu_z  in  1 each  ALU carry and zero
- flag_c, flag_z  out  1 each  architectural flags
- done  out  1  one-cycle pulse after write-back
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational read of register file (r0 reads 0)

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 NOT (A only), 7 SHL (A only), 8 SHR (A only), 9 CMP (SUB, no reg write), 10 MOV (A=rs, B=0, add), 11 LDI (A=0, B=imm, add), 12-15 reserved = NOP.
- Exactly one alu_* op select high for ops 1-9 (CMP drives alu_subtract); ops 0,10,11 and NOP drive all selects 0.
- B operand = instr_imm when instr_imm_en, else reg[rt]; for MOV B=0, for LDI A=0 and B=imm regardless of imm_en.
- alu_half_mode/alu_bytewise_mode = instr_half/instr_byte for ops 0-9; forced 0 for MOV, LDI, NOP.
- States: IDLE -> (instr_valid & instr_ready) -> EXEC -> WB -> IDLE. No other transitions.
- Accept (IDLE edge): latch rd/op; load alu_a, alu_b, selects, modes from decode and register file read.
- EXEC edge: capture alu_sum, alu_cout, alu_z into result registers.
- WB edge: if op in {0-8,10,11} and rd != 0 write reg[rd] = captured sum (full 16 bits; upper byte already zero in half mode); if op in 0-9 update flag_c, flag_z; MOV, LDI, NOP leave flags unchanged; clear all alu_* outputs to 0; done = 1 for the following cycle.
- Writes to r0 discarded; reads of r0 (rs, rt, dbg) return 0.
- instr_* inputs ignored outside IDLE; valid without ready is not consumed.

## Timing
- Reset (async assert, sync-free deassert to IDLE): state IDLE, instr_ready 1, all alu_* 0, flag_c/flag_z 0, done 0, all registers 0.
- Reset mid-EXEC/WB: instruction aborted, no register or flag write.
- Latency: accept at edge E0, result captured E1, write-back E2, done high cycle after E2, dbg_data shows new value from E2.
- instr_ready low after E0 until E2; next accept earliest E3; throughput 1 per 3 cycles.
- Back-to-back dependency (rs of next = rd of previous) needs no forwarding: write at E2 precedes read at E3.
- alu_* stable from E0 through E2 so ALU combinational path (incl. multiplier) has one full cycle to settle.

## Test plan
- Reset then LDI r1,0x1234 -> dbg r1 = 0x1234 at E2, done pulse 1 cycle, flags 0/0 unchanged.
- r1=0x0005, r2=0x0005, CMP r1,r2 -> alu_subtract=1 during EXEC, flag_z=1, flag_c=0, r1/r2 unchanged, no write.
- r1=0xFFFF, r2=0x0001, ADD r3,r1,r2 -> r3=0x0000, flag_c=1, flag_z=1; same with instr_half -> r3=0x0000, flag_c=1 (bits 16:8 nonzero).
- LDI r0,0xBEEF -> dbg r0 = 0; MUL r4,r5,r6 with r5=0x0100, r6=0x0003 -> r4=0x0300.
- Hold instr_valid for 3 instructions -> accepts at E0, E3, E6 only; instr_ready low in EXEC/WB; op 13 -> done pulses, no reg/flag change.
- Deassert rst_n during EXEC of ADD r1 -> instr_ready 1 immediately, r1 = 0, flags 0, done 0.
